// File: rtl/mem_lsu_if.sv
// EX/MEM operand bundle, data SRAM port and MEM/WB writeback bundle of the MEM-stage load/store unit.
// The slave modport is the load/store unit; the master modport is the surrounding pipeline and SRAM.
interface mem_lsu_if;
  logic [31:0] mem_data;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [3:0]  mem_lsop;
  logic [31:0] mem_memaddr;
  logic [31:0] mem_reg2;
  logic [31:0] mem_pc;
  logic        memDelay_i;

  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;

  logic [31:0] wb_wdata;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_pc;
  logic        wbDelay_o;
  logic        exc_adel;
  logic        exc_ades;
  logic [31:0] exc_badvaddr;

  modport slave (
    input  mem_data, mem_wd, mem_wreg, mem_lsop, mem_memaddr, mem_reg2, mem_pc, memDelay_i,
    input  data_sram_rdata,
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    output wb_wdata, wb_wd, wb_wreg, wb_pc, wbDelay_o, exc_adel, exc_ades, exc_badvaddr
  );

  modport master (
    output mem_data, mem_wd, mem_wreg, mem_lsop, mem_memaddr, mem_reg2, mem_pc, memDelay_i,
    output data_sram_rdata,
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    input  wb_wdata, wb_wd, wb_wreg, wb_pc, wbDelay_o, exc_adel, exc_ades, exc_badvaddr
  );
endinterface

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit and MEM/WB register: drives the data SRAM, stalls one cycle per load.
// Optional feature: define MEM_ADDR_EXC_EN to raise address-error exceptions on misaligned halfword/word accesses.
module mem_lsu (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] stall,
  output logic       stallreq_mem,
  mem_lsu_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_e;

  typedef struct packed {
    logic [31:0] wdata;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] pc;
    logic        delay;
    logic        adel;
    logic        ades;
    logic [31:0] badvaddr;
  } wb_t;

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  state_e      state_q, state_d;
  wb_t         wb_q, wb_d, pass_wb, load_wb;
  logic [31:0] load_buf_q, load_buf_d;
  logic        is_load, is_store, misaligned, load_req, store_req;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_wdata;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] aligned_rdata;
  logic        unused_stall;

  assign unused_stall = ^stall[3:0];

  // Op decode; a misaligned access is neither a load nor a store as far as the SRAM is concerned.
  always_comb begin
    is_load  = bus.mem_lsop inside {[OP_LB:OP_LW]};
    is_store = bus.mem_lsop inside {[OP_SB:OP_SW]};
`ifdef MEM_ADDR_EXC_EN
    misaligned = ((bus.mem_lsop == OP_LH || bus.mem_lsop == OP_LHU || bus.mem_lsop == OP_SH)
                  && bus.mem_memaddr[0])
              || ((bus.mem_lsop == OP_LW || bus.mem_lsop == OP_SW)
                  && (bus.mem_memaddr[1:0] != 2'b00));
`else
    misaligned = 1'b0;
`endif
    load_req  = is_load  & ~misaligned;
    store_req = is_store & ~misaligned;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (load_req) state_d = WAIT;
      WAIT:    state_d = stall[4] ? HOLD : IDLE;
      HOLD:    if (!stall[4]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sram_en      = 1'b0;
    stallreq_mem = 1'b0;
    if (state_q == IDLE) begin
      if (load_req) begin
        sram_en      = 1'b1;
        stallreq_mem = 1'b1;
      end else if (store_req && !stall[4]) begin
        sram_en = 1'b1;
      end
    end
  end

  always_comb begin
    sram_wen   = 4'b0000;
    sram_wdata = bus.mem_reg2;
    case (bus.mem_lsop)
      OP_SB: begin
        sram_wen   = 4'b0001 << bus.mem_memaddr[1:0];
        sram_wdata = {4{bus.mem_reg2[7:0]}};
      end
      OP_SH: begin
        sram_wen   = bus.mem_memaddr[1] ? 4'b1100 : 4'b0011;
        sram_wdata = {2{bus.mem_reg2[15:0]}};
      end
      OP_SW:   sram_wen = 4'b1111;
      default: ;
    endcase
    if (!(sram_en && store_req)) sram_wen = 4'b0000;
  end

  assign bus.data_sram_en    = sram_en;
  assign bus.data_sram_wen   = sram_wen;
  assign bus.data_sram_addr  = {bus.mem_memaddr[31:2], 2'b00};
  assign bus.data_sram_wdata = sram_wdata;

  // Lane extraction of returned read data; mem_* stays stable while the load is outstanding.
  always_comb begin
    rd_byte = bus.data_sram_rdata[{bus.mem_memaddr[1:0], 3'b000} +: 8];
    rd_half = bus.mem_memaddr[1] ? bus.data_sram_rdata[31:16] : bus.data_sram_rdata[15:0];
    case (bus.mem_lsop)
      OP_LB:   aligned_rdata = {{24{rd_byte[7]}}, rd_byte};
      OP_LBU:  aligned_rdata = {24'h0, rd_byte};
      OP_LH:   aligned_rdata = {{16{rd_half[15]}}, rd_half};
      OP_LHU:  aligned_rdata = {16'h0, rd_half};
      default: aligned_rdata = bus.data_sram_rdata;
    endcase
  end

  always_comb begin
    load_buf_d = (state_q == WAIT) ? aligned_rdata : load_buf_q;
  end

  always_comb begin
    pass_wb.wdata    = bus.mem_data;
    pass_wb.wd       = bus.mem_wd;
    pass_wb.wreg     = bus.mem_wreg & ~misaligned;
    pass_wb.pc       = bus.mem_pc;
    pass_wb.delay    = bus.memDelay_i;
    pass_wb.adel     = misaligned & is_load;
    pass_wb.ades     = misaligned & is_store;
    pass_wb.badvaddr = misaligned ? bus.mem_memaddr : 32'h0;

    load_wb          = pass_wb;
    load_wb.wdata    = (state_q == WAIT) ? aligned_rdata : load_buf_q;
    load_wb.wreg     = bus.mem_wreg;
    load_wb.adel     = 1'b0;
    load_wb.ades     = 1'b0;
    load_wb.badvaddr = 32'h0;
  end

  // A finishing load wins over the generic stall rule; a new load request always leaves a bubble.
  always_comb begin
    wb_d = wb_q;
    if ((state_q == WAIT || state_q == HOLD) && !stall[4]) wb_d = load_wb;
    else if (state_q == IDLE && !load_req && !stall[4])    wb_d = pass_wb;
    else if (!stall[5])                                    wb_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q       <= '0;
      load_buf_q <= 32'h0;
    end else begin
      wb_q       <= wb_d;
      load_buf_q <= load_buf_d;
    end
  end

  assign bus.wb_wdata     = wb_q.wdata;
  assign bus.wb_wd        = wb_q.wd;
  assign bus.wb_wreg      = wb_q.wreg;
  assign bus.wb_pc        = wb_q.pc;
  assign bus.wbDelay_o    = wb_q.delay;
  assign bus.exc_adel     = wb_q.adel;
  assign bus.exc_ades     = wb_q.ades;
  assign bus.exc_badvaddr = wb_q.badvaddr;

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed cases with literal expectations, then randomized traffic
// compared every cycle against a transaction-level model of the load/store unit.
module tb_mem_lsu;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] stall;
  logic       stallreq_mem;

  mem_lsu_if bus ();

  mem_lsu dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .stallreq_mem (stallreq_mem),
    .bus          (bus)
  );

  always #5 clk = ~clk;

`ifdef MEM_ADDR_EXC_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] wdata;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] pc;
    logic        dly;
    logic        adel;
    logic        ades;
    logic [31:0] badv;
  } wb_s;

  int          checks = 0;
  int          errors = 0;
  wb_s         exp_wb, nxt_wb;
  int          phase, nxt_phase;   // 0: no load outstanding, 1: read data due this cycle, 2: data buffered
  logic [31:0] m_buf, nxt_buf;
  bit          consumed, nxt_consumed;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic wb_s zero_wb();
    wb_s z;
    z.wdata = 0; z.wd = 0; z.wreg = 0; z.pc = 0; z.dly = 0; z.adel = 0; z.ades = 0; z.badv = 0;
    return z;
  endfunction

  function automatic bit f_load(input logic [3:0] op);
    return op >= 4'd1 && op <= 4'd5;
  endfunction

  function automatic bit f_store(input logic [3:0] op);
    return op >= 4'd6 && op <= 4'd8;
  endfunction

  function automatic bit f_mis(input logic [3:0] op, input logic [31:0] addr);
    int need;
    need = (op == 4'd3 || op == 4'd4 || op == 4'd7) ? 2 : (op == 4'd5 || op == 4'd8) ? 4 : 1;
    return EXC_EN && (addr % need != 0);
  endfunction

  function automatic logic [31:0] load_val(input logic [3:0] op, input logic [31:0] addr,
                                           input logic [31:0] rdata);
    int      lane, hlane;
    byte     sb;
    shortint sh;
    lane  = int'(addr[1:0]) * 8;
    hlane = addr[1] ? 16 : 0;
    sb    = byte'(rdata >> lane);
    sh    = shortint'(rdata >> hlane);
    case (op)
      4'd1:    return int'(sb);
      4'd2:    return (rdata >> lane) & 32'hFF;
      4'd3:    return int'(sh);
      4'd4:    return (rdata >> hlane) & 32'hFFFF;
      default: return rdata;
    endcase
  endfunction

  task automatic compare();
    logic [3:0]  op;
    logic [31:0] addr, e_wdata;
    logic [3:0]  e_wen;
    bit          busy, ld, st, e_en, e_req;
    op    = bus.mem_lsop;
    addr  = bus.mem_memaddr;
    busy  = (phase != 0);
    ld    = f_load(op)  && !f_mis(op, addr);
    st    = f_store(op) && !f_mis(op, addr);
    e_en  = !busy && (ld || (st && !stall[4]));
    e_req = !busy && ld;
    e_wen = 4'h0;
    if (e_en && st) begin
      case (op)
        4'd6:    e_wen = 4'b0001 << addr[1:0];
        4'd7:    e_wen = addr[1] ? 4'hC : 4'h3;
        default: e_wen = 4'hF;
      endcase
    end
    check("sram_en",   32'(bus.data_sram_en), 32'(e_en));
    check("stallreq",  32'(stallreq_mem),     32'(e_req));
    check("sram_addr", bus.data_sram_addr,    addr & ~32'h3);
    check("sram_wen",  32'(bus.data_sram_wen), 32'(e_wen));
    if (e_en && st) begin
      case (op)
        4'd6:    e_wdata = bus.mem_reg2[7:0]  * 32'h01010101;
        4'd7:    e_wdata = bus.mem_reg2[15:0] * 32'h00010001;
        default: e_wdata = bus.mem_reg2;
      endcase
      check("sram_wdata", bus.data_sram_wdata, e_wdata);
    end
    check("wb_wdata", bus.wb_wdata,          exp_wb.wdata);
    check("wb_wd",    32'(bus.wb_wd),        32'(exp_wb.wd));
    check("wb_wreg",  32'(bus.wb_wreg),      32'(exp_wb.wreg));
    check("wb_pc",    bus.wb_pc,             exp_wb.pc);
    check("wb_delay", 32'(bus.wbDelay_o),    32'(exp_wb.dly));
    check("exc_adel", 32'(bus.exc_adel),     32'(exp_wb.adel));
    check("exc_ades", 32'(bus.exc_ades),     32'(exp_wb.ades));
    check("exc_badv", bus.exc_badvaddr,      exp_wb.badv);
  endtask

  // What the writeback register and outstanding-load bookkeeping become at the coming edge.
  task automatic model_edge();
    logic [3:0]  op;
    logic [31:0] addr;
    bit          mis;
    wb_s         pass, idle_wb;
    op   = bus.mem_lsop;
    addr = bus.mem_memaddr;
    mis  = f_mis(op, addr);
    pass.wdata = bus.mem_data;
    pass.wd    = bus.mem_wd;
    pass.wreg  = bus.mem_wreg && !mis;
    pass.pc    = bus.mem_pc;
    pass.dly   = bus.memDelay_i;
    pass.adel  = mis && f_load(op);
    pass.ades  = mis && f_store(op);
    pass.badv  = mis ? addr : 32'h0;
    idle_wb    = stall[5] ? exp_wb : zero_wb();
    nxt_buf      = m_buf;
    nxt_phase    = phase;
    nxt_consumed = 1'b0;
    nxt_wb       = idle_wb;
    if (rst) begin
      nxt_wb = zero_wb(); nxt_phase = 0; nxt_buf = 0; nxt_consumed = 1'b1;
    end else if (phase != 0 && !stall[4]) begin
      nxt_wb       = pass;
      nxt_wb.wdata = (phase == 1) ? load_val(op, addr, bus.data_sram_rdata) : m_buf;
      nxt_wb.wreg  = bus.mem_wreg;
      nxt_phase    = 0;
      nxt_consumed = 1'b1;
    end else if (phase == 1) begin
      nxt_buf   = load_val(op, addr, bus.data_sram_rdata);
      nxt_phase = 2;
    end else if (phase == 0 && f_load(op) && !mis) begin
      nxt_phase = 1;
    end else if (phase == 0 && !stall[4]) begin
      nxt_wb       = pass;
      nxt_consumed = 1'b1;
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare();
    model_edge();
    @(posedge clk);
    #1;
    exp_wb   = nxt_wb;
    phase    = nxt_phase;
    m_buf    = nxt_buf;
    consumed = nxt_consumed;
  endtask

  task automatic set_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                        input logic [31:0] data, input logic wreg);
    bus.mem_lsop    = op;
    bus.mem_memaddr = addr;
    bus.mem_reg2    = reg2;
    bus.mem_data    = data;
    bus.mem_wd      = 5'($urandom_range(1, 31));
    bus.mem_wreg    = wreg;
    bus.mem_pc      = $urandom & ~32'h3;
    bus.memDelay_i  = 1'($urandom);
  endtask

  initial begin
    rst = 1'b1;
    stall = 6'h0;
    bus.data_sram_rdata = 32'h0;
    set_op(4'd0, 32'h0, 32'h0, 32'h0, 1'b0);
    exp_wb = zero_wb();
    phase = 0; m_buf = 0; consumed = 1'b1;
    @(posedge clk); #1;
    step();
    rst = 1'b0;
    check("rst_wb_wdata", bus.wb_wdata, 32'h0);
    check("rst_wb_wreg",  32'(bus.wb_wreg), 32'h0);
    check("rst_exc_badv", bus.exc_badvaddr, 32'h0);

    // LW 0x100: one stall cycle, value written two edges after entry
    set_op(4'd5, 32'h100, 32'h0, 32'h0, 1'b1);
    #1 check("lw_stallreq", 32'(stallreq_mem), 32'h1);
    step();
    bus.data_sram_rdata = 32'hDEADBEEF;
    #1 check("lw_wait_stallreq", 32'(stallreq_mem), 32'h0);
    check("lw_wait_en", 32'(bus.data_sram_en), 32'h0);
    step();
    check("lw_wb_wdata", bus.wb_wdata, 32'hDEADBEEF);
    check("lw_wb_wreg",  32'(bus.wb_wreg), 32'h1);

    // LB / LBU at 0x103 pick the top byte
    set_op(4'd1, 32'h103, 32'h0, 32'h0, 1'b1);
    step();
    bus.data_sram_rdata = 32'h80123456;
    step();
    check("lb_wb_wdata", bus.wb_wdata, 32'hFFFFFF80);
    set_op(4'd2, 32'h103, 32'h0, 32'h0, 1'b1);
    step();
    bus.data_sram_rdata = 32'h80123456;
    step();
    check("lbu_wb_wdata", bus.wb_wdata, 32'h00000080);

    // SH at 0x102: upper lane pair, no stall
    set_op(4'd7, 32'h102, 32'h0000ABCD, 32'h0, 1'b0);
    #1 check("sh_en", 32'(bus.data_sram_en), 32'h1);
    check("sh_wen",      32'(bus.data_sram_wen), 32'hC);
    check("sh_wdata",    bus.data_sram_wdata, 32'hABCDABCD);
    check("sh_stallreq", 32'(stallreq_mem), 32'h0);
    step();

    // LW held by stall[4] for three cycles; later rdata changes must not leak through
    set_op(4'd5, 32'h104, 32'h0, 32'h0, 1'b1);
    step();
    bus.data_sram_rdata = 32'h11223344;
    stall = 6'b011111;
    step();
    for (int i = 0; i < 2; i++) begin
      bus.data_sram_rdata = $urandom;
      step();
    end
    check("hold_bubble", bus.wb_wdata, 32'h0);
    stall = 6'h0;
    bus.data_sram_rdata = 32'hCAFEF00D;
    step();
    check("hold_release", bus.wb_wdata, 32'h11223344);

    // Reset while the load is outstanding abandons it
    set_op(4'd5, 32'h108, 32'h0, 32'h0, 1'b1);
    step();
    rst = 1'b1;
    bus.data_sram_rdata = 32'h99999999;
    step();
    rst = 1'b0;
    check("rstwait_wdata", bus.wb_wdata, 32'h0);
    check("rstwait_wreg",  32'(bus.wb_wreg), 32'h0);
    #1 check("rstwait_idle", 32'(stallreq_mem), 32'h1);
    set_op(4'd0, 32'h0, 32'h0, 32'h55, 1'b0);
    step();
    check("rstwait_after", bus.wb_wdata, 32'h55);

    // SW at a misaligned address
    set_op(4'd8, 32'h101, 32'h12345678, 32'h0, 1'b0);
`ifdef MEM_ADDR_EXC_EN
    #1 check("sw_mis_en", 32'(bus.data_sram_en), 32'h0);
    check("sw_mis_stallreq", 32'(stallreq_mem), 32'h0);
    step();
    check("sw_mis_ades", 32'(bus.exc_ades), 32'h1);
    check("sw_mis_badv", bus.exc_badvaddr, 32'h101);
    check("sw_mis_wreg", 32'(bus.wb_wreg), 32'h0);
`else
    #1 check("sw_mis_wen", 32'(bus.data_sram_wen), 32'hF);
    check("sw_mis_addr", bus.data_sram_addr, 32'h100);
    step();
    check("sw_mis_ades", 32'(bus.exc_ades), 32'h0);
`endif

    // Randomized traffic; operands change only once the model says the instruction left MEM
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      if (consumed)
        set_op(4'($urandom), 32'h100 + 32'($urandom_range(0, 63)), $urandom, $urandom,
               1'($urandom));
      stall[4] = ($urandom_range(0, 3) == 0);
      stall[5] = stall[4] && ($urandom_range(0, 2) == 0);
      stall[3:0] = 4'($urandom);
      bus.data_sram_rdata = $urandom;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

MEM-stage load/store unit and MEM/WB pipeline register for the five-stage MIPS core. Consumes the EX/MEM register outputs (result, destination, write enable, load/store op, effective address, store data, PC, delay-slot flag). Drives the synchronous data SRAM port, stalls the pipeline for one cycle on loads, aligns and extends load data, and registers the writeback bundle for WB.

## Interface
- No parameters.
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  6  pipeline stall vector; bit 4 = MEM held, bit 5 = WB held
- stallreq_mem  out  1  combinational stall request to the stall controller
- mem_data / mem_wd / mem_wreg  in  32/5/1  ALU result, destination reg, write enable
- mem_lsop  in  4  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9–15 treated as none
- mem_memaddr / mem_reg2  in  32/32  effective address, store data
- mem_pc / memDelay_i  in  32/1  instruction PC, delay-slot flag
- data_sram_en  out  1  SRAM access enable (combinational)
- data_sram_wen  out  4  byte write strobes, bit n = byte lane n (combinational)
- data_sram_addr  out  32  {mem_memaddr[31:2],2'b00}
- data_sram_wdata  out  32  store data replicated across lanes
- data_sram_rdata  in  32  read data, valid the cycle after an enabled read
- wb_wdata / wb_wd / wb_wreg  out  32/5/1  registered writeback bundle
- wb_pc / wbDelay_o  out  32/1  registered PC, delay-slot flag
- exc_adel / exc_ades / exc_badvaddr  out  1/1/32  registered address-error flags, faulting address

## Operation
- Little-endian; lane = addr[1:0]. Halfword lane pair = addr[1].
- Stores: data_sram_en=1 while state IDLE and stall[4]=0; SB wen=4'b0001<<addr[1:0], wdata={4{reg2[7:0]}}; SH wen=4'b0011 or 4'b1100, wdata={2{reg2[15:0]}}; SW wen=4'b1111, wdata=reg2. Store writeback: wb_wreg carries mem_wreg (0 from decode).
- Loads: wen=0. Extraction by lane; LB/LH sign-extend, LBU/LHU zero-extend, LW as-is. Result replaces mem_data in writeback.
- FSM states IDLE, WAIT, HOLD.
  - IDLE, load present: data_sram_en=1, stallreq_mem=1 → WAIT. WB register takes a bubble (all zero).
  - WAIT: data_sram_en=0, stallreq_mem=0; aligned rdata captured into load buffer. stall[4]=0 → WB loads buffer, → IDLE. stall[4]=1 → HOLD.
  - HOLD: data_sram_en=0; WB loads buffer when stall[4]=0, → IDLE.
- Non-load ops in IDLE: WB register loads pass-through bundle when stall[4]=0.
- WB register rule: stall[4]=1 & stall[5]=0 → bubble (all outputs 0); stall[4]=0 → load; else hold. Load result takes precedence when leaving WAIT/HOLD.

## Timing
- rst: state IDLE; all wb_*, exc_*, load buffer = 0. Reset in WAIT/HOLD abandons the load, no writeback; SRAM outputs go combinationally from current inputs.
- Load latency: request in cycle N, rdata at N+1, wb_* valid after edge ending N+1 (one stall cycle). Store/ALU: wb_* valid after edge ending N.
- mem_* inputs held stable by upstream stall during WAIT; unit still uses the captured buffer, not live rdata, after WAIT.
- Back-to-back loads: each costs one stall cycle; IDLE re-entered before second request.

## Configuration
- MEM_ADDR_EXC_EN defined: LH/LHU with addr[0]≠0 or LW with addr[1:0]≠0 → exc_adel=1; SH/SW likewise → exc_ades=1; exc_badvaddr=mem_memaddr; SRAM access suppressed (en=0), no stall, wb_wreg=0. Flags registered with WB bundle, same bubble/hold rules.
- Undefined: low address bits ignored for halfword/word (lane forced to aligned), exc_* tied 0.

## Test plan
- LW addr 0x100, rdata 0xDEADBEEF → stallreq_mem high one cycle, wb_wdata=0xDEADBEEF, wb_wreg=1 two edges after entry.
- LB addr 0x103, rdata 0x80123456 → wb_wdata=0xFFFFFF80; LBU same → 0x00000080.
- SH addr 0x102, reg2 0x0000ABCD → en=1, wen=4'b1100, wdata=0xABCDABCD, no stall.
- LW with stall[4] held 3 cycles after WAIT → state HOLD, rdata changing has no effect, buffered value written on release.
- rst asserted in WAIT → all outputs 0, state IDLE, no writeback.
- With MEM_ADDR_EXC_EN: SW addr 0x101 → en=0, exc_ades=1, exc_badvaddr=0x101, wb_wreg=0; without it: wen=4'b1111, addr 0x100.
